// File: rtl/pc_fetch_sequencer_if.sv
// Fetch-side bundle between the execute/hazard logic, the PC sequencer and
// instruction memory. The sequencer sits on the slave side.
interface pc_fetch_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             stall;
  logic             fetch_ready;
  logic             instr_is_16;
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_target;
  logic             trap_valid;
  logic [WIDTH-1:0] trap_vector;
  logic [WIDTH-1:0] pc_out;
  logic             pc_valid;
  logic [WIDTH-1:0] pc_plus_inc;
  logic             misaligned_err;
  logic [WIDTH-1:0] misaligned_addr;

  modport master (
    output stall, fetch_ready, instr_is_16, redirect_valid, redirect_target,
           trap_valid, trap_vector,
    input  pc_out, pc_valid, pc_plus_inc, misaligned_err, misaligned_addr
  );

  modport slave (
    input  stall, fetch_ready, instr_is_16, redirect_valid, redirect_target,
           trap_valid, trap_vector,
    output pc_out, pc_valid, pc_plus_inc, misaligned_err, misaligned_addr
  );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Fetch PC register with sequential/redirect/trap next-PC selection, a one-entry
// pending-redirect buffer for stalls, and misaligned-target detection.
module pc_fetch_sequencer #(
  parameter int               WIDTH         = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR  = '0,
  parameter bit               COMPRESSED_EN = 1'b0
) (
  input logic                 clk,
  input logic                 rst_n,
  pc_fetch_sequencer_if.slave bus
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_ERR  = 2'd2;

  localparam logic [WIDTH-1:0] ALIGN_MASK = COMPRESSED_EN ? WIDTH'(1) : WIDTH'(3);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             pend_valid_q, pend_valid_d;
  logic [WIDTH-1:0] pend_target_q, pend_target_d;
  logic [WIDTH-1:0] err_addr_q, err_addr_d;
  logic [WIDTH-1:0] inc;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] trap_pc;
  logic             fire;

  assign inc     = (COMPRESSED_EN && bus.instr_is_16) ? WIDTH'(2) : WIDTH'(4);
  assign pc_inc  = pc_q + inc;
  assign trap_pc = bus.trap_vector & ~ALIGN_MASK;
  assign fire    = bus.fetch_ready & ~bus.stall;

  function automatic logic is_misaligned(input logic [WIDTH-1:0] addr);
    return |(addr & ALIGN_MASK);
  endfunction

  always_comb begin
    // NOTE: every target gets a default here so the block stays purely
    // combinational; a missing default on any branch would infer a latch.
    state_d       = state_q;
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    err_addr_d    = err_addr_q;

    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
        if (bus.trap_valid) begin
          pc_d         = trap_pc;
          pend_valid_d = 1'b0;
        end
      end

      ST_RUN: begin
        if (bus.trap_valid) begin
          pc_d         = trap_pc;
          pend_valid_d = 1'b0;
        end else if (bus.redirect_valid && !bus.stall) begin
          // A live redirect supersedes anything still parked in the buffer.
          pend_valid_d = 1'b0;
          if (is_misaligned(bus.redirect_target)) begin
            state_d    = ST_ERR;
            err_addr_d = bus.redirect_target;
          end else begin
            pc_d = bus.redirect_target;
          end
        end else if (bus.redirect_valid && bus.stall) begin
          pend_valid_d  = 1'b1;
          pend_target_d = bus.redirect_target;
        end else if (pend_valid_q && !bus.stall) begin
          pend_valid_d = 1'b0;
          if (is_misaligned(pend_target_q)) begin
            state_d    = ST_ERR;
            err_addr_d = pend_target_q;
          end else begin
            pc_d = pend_target_q;
          end
        end else if (fire) begin
          pc_d = pc_inc;
        end
      end

      ST_ERR: begin
        if (bus.trap_valid) begin
          pc_d         = trap_pc;
          pend_valid_d = 1'b0;
          state_d      = ST_RUN;
        end
      end

      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_VECTOR;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
      err_addr_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments let every register sample the pre-edge
      // values together, so the order of these lines does not matter.
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      err_addr_q    <= err_addr_d;
    end
  end

  assign bus.pc_out          = pc_q;
  assign bus.pc_valid        = (state_q == ST_RUN);
  assign bus.pc_plus_inc     = pc_inc;
  assign bus.misaligned_err  = (state_q == ST_ERR);
  assign bus.misaligned_addr = err_addr_q;

endmodule
